// File: rtl/mtm_alu_deserializer.sv
// Serial frame deserializer for the MTM ALU: assembles 8 data bytes plus a command byte into A/B/op and flags errors.
// Optional CRC-4 checking is enabled by defining MTM_ALU_DESER_CRC_CHECK_EN.
module mtm_alu_deserializer #(
   parameter int DATA_BYTES = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sin,
   output logic        out_valid,
   output logic [31:0] a_out,
   output logic [31:0] b_out,
   output logic [2:0]  op_out,
   output logic        err_data,
   output logic        err_crc,
   output logic        err_op
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] TYPE    = 2'd1;
   localparam logic [1:0] PAYLOAD = 2'd2;
   localparam logic [1:0] STOP    = 2'd3;

   logic [1:0]  state;
   logic [2:0]  bit_cnt;
   logic        is_cmd;
   logic [7:0]  shift_byte;
   logic [3:0]  data_cnt;
   logic [63:0] ba;
   logic        frame_err;

   logic        bad_data;
   logic        crc_bad;
   logic        op_bad;
   logic [2:0]  cmd_op;

`ifdef MTM_ALU_DESER_CRC_CHECK_EN
   // Serial LFSR form of x^4+x+1 with zero seed, message MSB first.
   function automatic logic [3:0] crc4_d68(input logic [67:0] d);
      logic [3:0] c;
      logic       fb;
      c = 4'h0;
      for (int i = 67; i >= 0; i--) begin
         fb = d[i] ^ c[3];
         c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
      end
      return c;
   endfunction
`endif

   assign cmd_op = shift_byte[6:4];

   // Close-of-packet checks; only meaningful while sampling a command frame's stop bit.
   always_comb begin
      bad_data = (data_cnt != 4'(DATA_BYTES)) || frame_err || !sin;
      op_bad   = !(cmd_op inside {3'b000, 3'b001, 3'b100, 3'b101});
`ifdef MTM_ALU_DESER_CRC_CHECK_EN
      crc_bad  = crc4_d68({ba, 1'b1, cmd_op}) != shift_byte[3:0];
`else
      crc_bad  = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bit_cnt    <= 3'd0;
         is_cmd     <= 1'b0;
         shift_byte <= 8'h00;
         data_cnt   <= 4'd0;
         ba         <= 64'h0;
         frame_err  <= 1'b0;
         out_valid  <= 1'b0;
         a_out      <= 32'h0;
         b_out      <= 32'h0;
         op_out     <= 3'b000;
         err_data   <= 1'b0;
         err_crc    <= 1'b0;
         err_op     <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (!sin) state <= TYPE;
            end
            TYPE: begin
               is_cmd  <= sin;
               bit_cnt <= 3'd0;
               state   <= PAYLOAD;
            end
            PAYLOAD: begin
               shift_byte <= {shift_byte[6:0], sin};
               bit_cnt    <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state <= STOP;
            end
            default: begin
               state <= IDLE;
               if (is_cmd) begin
                  // A command frame always closes the packet, even with a bad stop bit.
                  out_valid <= 1'b1;
                  a_out     <= ba[31:0];
                  b_out     <= ba[63:32];
                  op_out    <= cmd_op;
                  err_data  <= bad_data;
                  err_crc   <= !bad_data && crc_bad;
                  err_op    <= !bad_data && !crc_bad && op_bad;
                  data_cnt  <= 4'd0;
                  ba        <= 64'h0;
                  frame_err <= 1'b0;
               end else if (sin) begin
                  ba <= {ba[55:0], shift_byte};
                  if (data_cnt != 4'hF) data_cnt <= data_cnt + 4'd1;
               end else begin
                  frame_err <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed self-checking bench for mtm_alu_deserializer: drives bit-serial packets and checks outputs and error flags.
module tb_mtm_alu_deserializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sin;
   logic        out_valid;
   logic [31:0] a_out;
   logic [31:0] b_out;
   logic [2:0]  op_out;
   logic        err_data;
   logic        err_crc;
   logic        err_op;

   int tests_run    = 0;
   int tests_failed = 0;
   int valid_count  = 0;
   int start_count  = 0;
   int pre_count    = 0;
   logic exp_crc_err;

   mtm_alu_deserializer #(.DATA_BYTES(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sin       (sin),
      .out_valid (out_valid),
      .a_out     (a_out),
      .b_out     (b_out),
      .op_out    (op_out),
      .err_data  (err_data),
      .err_crc   (err_crc),
      .err_op    (err_op)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (out_valid) valid_count <= valid_count + 1;
   end

   // Reference CRC as polynomial long division of msg*x^4 by 10011.
   function automatic logic [3:0] crc_model(input logic [67:0] msg);
      logic [71:0] r;
      r = {msg, 4'b0000};
      for (int i = 71; i >= 4; i--) begin
         if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
      end
      return r[3:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic send_bit(input logic b);
      sin = b;
      @(negedge clk);
   endtask

   task automatic send_frame(input logic t, input logic [7:0] p, input logic stop);
      send_bit(1'b0);
      send_bit(t);
      for (int i = 7; i >= 0; i--) send_bit(p[i]);
      send_bit(stop);
   endtask

   // Sends n_data data frames (bytes of {b,a}, MSB first) then the command frame.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                input logic [3:0] crc_xor, input int n_data, input int bad_stop_idx);
      logic [63:0] ba;
      logic [3:0]  crc;
      ba  = {b, a};
      crc = crc_model({b, a, 1'b1, op}) ^ crc_xor;
      start_count = valid_count;
      for (int i = 0; i < n_data; i++) begin
         send_frame(1'b0, ba[63 - 8*i -: 8], (i + 1) != bad_stop_idx);
      end
      send_frame(1'b1, {1'b0, op, crc}, 1'b1);
   endtask

   task automatic check_result(input string tag, input logic [31:0] ea, input logic [31:0] eb, input logic [2:0] eop,
                               input logic ed, input logic ec, input logic eo);
      checkOutput({tag, " valid"},    64'(out_valid), 64'd1);
      checkOutput({tag, " a_out"},    64'(a_out),     64'(ea));
      checkOutput({tag, " b_out"},    64'(b_out),     64'(eb));
      checkOutput({tag, " op_out"},   64'(op_out),    64'(eop));
      checkOutput({tag, " err_data"}, 64'(err_data),  64'(ed));
      checkOutput({tag, " err_crc"},  64'(err_crc),   64'(ec));
      checkOutput({tag, " err_op"},   64'(err_op),    64'(eo));
      send_bit(1'b1);
      checkOutput({tag, " pulse end"},   64'(out_valid),   64'd0);
      checkOutput({tag, " pulse count"}, 64'(valid_count), 64'(start_count + 1));
   endtask

   initial begin
`ifdef MTM_ALU_DESER_CRC_CHECK_EN
      exp_crc_err = 1'b1;
`else
      exp_crc_err = 1'b0;
`endif
      rst_n = 1'b0;
      sin   = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset valid",    64'(out_valid), 64'd0);
      checkOutput("reset a_out",    64'(a_out),     64'd0);
      checkOutput("reset b_out",    64'(b_out),     64'd0);
      checkOutput("reset op_out",   64'(op_out),    64'd0);
      checkOutput("reset errs",     64'({err_data, err_crc, err_op}), 64'd0);
      rst_n = 1'b1;
      repeat (2) send_bit(1'b1);

      // Well-formed add packet; out_valid must appear 99 cycles after the first start bit.
      applyStimulus(32'h0000_0001, 32'h0000_0002, 3'b100, 4'h0, 8, 0);
      check_result("add ok", 32'h0000_0001, 32'h0000_0002, 3'b100, 1'b0, 1'b0, 1'b0);

      applyStimulus(32'h0000_0001, 32'h0000_0002, 3'b100, 4'h1, 8, 0);
      check_result("bad crc", 32'h0000_0001, 32'h0000_0002, 3'b100, 1'b0, exp_crc_err, 1'b0);

      // Seven data frames: bytes 55,66,77,88,11,22,33 land in the low 56 bits.
      applyStimulus(32'h1122_3344, 32'h5566_7788, 3'b000, 4'h0, 7, 0);
      check_result("short pkt", 32'h8811_2233, 32'h0055_6677, 3'b000, 1'b1, 1'b0, 1'b0);

      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111, 4'h0, 8, 0);
      check_result("bad op", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111, 1'b0, 1'b0, 1'b1);
      repeat (3) send_bit(1'b1);
      checkOutput("bad op held err_op", 64'(err_op), 64'd1);
      checkOutput("bad op held op_out", 64'(op_out), 64'd7);

      // Third frame (byte B3) discarded by its bad stop bit.
      applyStimulus(32'hA1A2_A3A4, 32'hB1B2_B3B4, 3'b001, 4'h0, 8, 3);
      check_result("bad stop", 32'hA1A2_A3A4, 32'h00B1_B2B4, 3'b001, 1'b1, 1'b0, 1'b0);

      applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 3'b101, 4'h0, 8, 0);
      check_result("recover", 32'h1234_5678, 32'h9ABC_DEF0, 3'b101, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of the fifth data frame, then a full packet.
      pre_count = valid_count;
      for (int i = 0; i < 4; i++) send_frame(1'b0, 8'h5A, 1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rst_n = 1'b0;
      sin   = 1'b1;
      @(negedge clk);
      checkOutput("mid reset a_out", 64'(a_out), 64'd0);
      checkOutput("mid reset errs",  64'({err_data, err_crc, err_op}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send_bit(1'b1);
      applyStimulus(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b001, 4'h0, 8, 0);
      check_result("after reset", 32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b001, 1'b0, 1'b0, 1'b0);
      checkOutput("after reset one pulse", 64'(valid_count), 64'(pre_count + 1));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mtm_alu_deserializer.md
# mtm_alu_deserializer

Serial-input front end of the MTM ALU. Consumes the bit-serial frame stream driven on `sin` (the same stream the tester BFM produces with `tx_packet`), assembles 8 data bytes plus one command byte into operands A, B, opcode and CRC, and checks framing, CRC and opcode. One `out_valid` pulse per completed packet hands A/B/op and error flags to the ALU core.

## Interface
- `DATA_BYTES`, default 8: number of data frames in a well-formed packet; fixed at 8 for the 32+32-bit ALU.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sin`  in  1  serial input, idle high, synchronous to `clk` (one bit per cycle).
- `out_valid`  out  1  one-cycle pulse: packet complete, outputs below are valid.
- `a_out`  out  32  operand A.
- `b_out`  out  32  operand B.
- `op_out`  out  3  opcode from command byte.
- `err_data`  out  1  wrong data-frame count or framing error in packet.
- `err_crc`  out  1  CRC mismatch.
- `err_op`  out  1  opcode not in {000 and, 001 or, 100 add, 101 sub}.

## Operation
- Frame = 11 bits: start `0`, type bit (`0` data, `1` command), 8 payload bits MSB first, stop `1`.
- Frame FSM: IDLE -> (sin==0) TYPE -> PAYLOAD (8 cycles, 3-bit counter) -> STOP -> IDLE. In IDLE, sin==1 keeps IDLE. Back-to-back frames allowed: start bit may arrive the cycle after STOP.
- Data frame: payload shifted into 64-bit register `{B,A}` (first byte -> B[31:24], eighth -> A[7:0]); data counter increments, saturating at 15.
- Command frame payload = `{1'b0, op[2:0], crc[3:0]}`; bit 7 ignored. Command frame closes the packet.
- Stop bit sampled as 0: frame discarded, packet-level framing flag set; flag and counter clear when packet closes.
- On packet close, flags evaluated in priority order; exactly one or none asserted:
  - data count != 8 or framing flag set -> `err_data`=1, others 0.
  - else CRC mismatch -> `err_crc`=1.
  - else opcode illegal -> `err_op`=1.
- CRC: CRC-4, polynomial x^4+x+1, initial value 0, computed over 68 bits `{B, A, 1'b1, op}` MSB first (identical to `nextCRC4_D68` in `mtm_alu_pkg`). Computed combinationally from the assembled register at packet close.
- `a_out`, `b_out`, `op_out` update only on `out_valid`; hold otherwise. On error packets they still load whatever was assembled (unfilled bytes keep prior register contents).
- Data count, `{B,A}` register and framing flag reset to 0 after each packet close.

## Timing
- Reset values: `out_valid`=0, `a_out`=0, `b_out`=0, `op_out`=0, all `err_*`=0; FSM=IDLE; counters 0. Assertion of `rst_n` mid-frame or mid-packet discards all partial state immediately.
- Latency: `out_valid` asserts the cycle after the command frame's stop bit is sampled; a well-formed packet is 99 cycles from first start bit to `out_valid`.
- `err_*` are valid with `out_valid` and held until next `out_valid` or reset.
- No backpressure: downstream must accept every pulse.
- Command frame with stop=0: still closes the packet, reported as `err_data`.
- Reset deassertion while `sin`=0: first sampled 0 treated as start bit.

## Configuration
- `MTM_ALU_DESER_CRC_CHECK_EN` defined: CRC computed and checked as above.
- Not defined: no CRC logic synthesized; `err_crc` tied 0; packets with bad CRC proceed to opcode check.

## Test plan
- A=0x0000_0001, B=0x0000_0002, op=100, correct CRC -> `out_valid` pulse after 99 cycles, a_out=0x1, b_out=0x2, op_out=100, all err=0.
- Same packet with CRC field XOR 0x1 -> `err_crc`=1 (macro defined); `err_crc`=0, no errors (macro undefined).
- Only 7 data frames then command -> `err_data`=1, `err_crc`=0, `err_op`=0.
- A=B=0xFFFF_FFFF, op=111, correct CRC -> `err_op`=1, op_out=111.
- Stop bit of 3rd data frame forced 0 -> `err_data`=1; next well-formed packet -> no errors.
- `rst_n` pulsed low during 5th data frame, then full valid packet -> exactly one `out_valid`, correct A/B, no errors.
